// File: rtl/risc_v_mike_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and fills IF/ID.
// Optional performance counters are enabled with RISC_V_MIKE_FETCH_PERF_CNT_EN.
module risc_v_mike_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_error
`ifdef RISC_V_MIKE_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  // 33-bit limit so that address comparisons never suffer from 32-bit wrap.
  localparam logic [32:0] ADDR_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] if_pc4_reg, if_pc4_next;
  logic        valid_reg, valid_next;
  logic        error_reg, error_next;

  logic [32:0] pc_plus4_wide;
  logic [31:0] pc_plus4;
  logic        seq_oob;
  logic        redirect_bad;

  assign pc_plus4_wide = {1'b0, pc_reg} + 33'd4;
  assign pc_plus4      = pc_plus4_wide[31:0];
  assign seq_oob       = (pc_plus4_wide >= ADDR_LIMIT);
  assign redirect_bad  = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= ADDR_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RUN;
      pc_reg     <= RESET_PC;
      instr_reg  <= NOP_INSTR;
      if_pc_reg  <= 32'd0;
      if_pc4_reg <= 32'd0;
      valid_reg  <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      if_pc_reg  <= if_pc_next;
      if_pc4_reg <= if_pc4_next;
      valid_reg  <= valid_next;
      error_reg  <= error_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    if_pc_next  = if_pc_reg;
    if_pc4_next = if_pc4_reg;
    valid_next  = valid_reg;
    error_next  = error_reg;

    case (state_reg)
      RUN: begin
        if (redirect_valid) begin
          // A bad target is never loaded; the PC keeps its last legal value.
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
          if (redirect_bad) begin
            state_next = HALT;
            error_next = 1'b1;
          end else begin
            pc_next = redirect_pc;
          end
        end else if (flush) begin
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
          if (!stall) begin
            if (seq_oob) begin
              state_next = HALT;
              error_next = 1'b1;
            end else begin
              pc_next = pc_plus4;
            end
          end
        end else if (stall) begin
          pc_next = pc_reg;
        end else if (seq_oob) begin
          state_next = HALT;
          error_next = 1'b1;
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
        end else begin
          pc_next     = pc_plus4;
          instr_next  = imem_rd_data;
          if_pc_next  = pc_reg;
          if_pc4_next = pc_plus4;
          valid_next  = 1'b1;
        end
      end
      HALT: begin
        // Everything holds; only reset leaves this state.
        state_next = HALT;
      end
      default: begin
        state_next = HALT;
        error_next = 1'b1;
      end
    endcase
  end

  assign imem_addr      = pc_reg;
  assign if_id_instr    = instr_reg;
  assign if_id_pc       = if_pc_reg;
  assign if_id_pc_plus4 = if_pc4_reg;
  assign if_id_valid    = valid_reg;
  assign fetch_error    = error_reg;

`ifdef RISC_V_MIKE_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg, fetch_cnt_next;
  logic [31:0] stall_cnt_reg, stall_cnt_next;
  logic        fetch_load;
  logic        stall_event;

  // A fetch counts only when a real instruction is loaded, not when one is held.
  assign fetch_load  = (state_reg == RUN) && !redirect_valid && !flush && !stall && !seq_oob;
  assign stall_event = (state_reg == RUN) && stall && !redirect_valid;

  always_comb begin
    fetch_cnt_next = fetch_cnt_reg;
    stall_cnt_next = stall_cnt_reg;
    if (fetch_load) begin
      fetch_cnt_next = fetch_cnt_reg + 32'd1;
    end
    if (stall_event) begin
      stall_cnt_next = stall_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_reg <= 32'd0;
      stall_cnt_reg <= 32'd0;
    end else begin
      fetch_cnt_reg <= fetch_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule
